// File: rtl/vx_pending_scoreboard_pkg.sv
// rtl/vx_pending_scoreboard_pkg.sv - shared widths, index derivations and payload type for the pending scoreboard
//   DEF_CNT_W   : default width of a per-register pending-write counter
//   DEF_ASYNC_W : default width of the per-warp async in-flight counter
//   DEF_DATAW   : default opaque payload width
//   calc_wis_w / calc_rw : warp-index and register-index widths
package vx_pending_scoreboard_pkg;

    localparam int DEF_CNT_W   = 2;
    localparam int DEF_ASYNC_W = 4;
    localparam int DEF_DATAW   = 64;

    // A single warp still needs a one-bit index so the ports never collapse to zero width.
    function automatic int calc_wis_w(input int num_warps);
        return (num_warps > 1) ? $clog2(num_warps) : 1;
    endfunction

    function automatic int calc_rw(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

    typedef struct packed {
        logic [DEF_DATAW-1:0] data;
    } payload_t;

endpackage

// File: rtl/vx_stream_buffer.sv
// rtl/vx_stream_buffer.sv - two-entry registered output stage for one issue channel
//   in_valid / in_ready / in_data    : push side; in_ready depends only on stored occupancy
//   out_valid / out_ready / out_data : pop side; out_valid rises the cycle after a push
module vx_stream_buffer #(
    parameter int DATAW = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [DATAW-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [DATAW-1:0] out_data,
    input  logic             out_ready
);

    logic [DATAW-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    // Two entries let a full-rate stream continue while out_ready is sampled
    // only through registered state, so in_ready never sees out_ready combinationally.
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/vx_pending_scoreboard.sv
// rtl/vx_pending_scoreboard.sv - per-warp register pending-write scoreboard with async tracking and output staging
//   in_*           : issue request per channel (warp, rd, rs1..rs3, writeback/async flags, payload)
//   out_*          : staged issued payload per channel
//   wb_*           : writeback / async-completion events per channel
//   timeout        : channel has been stalled for TIMEOUT consecutive cycles
//   err_underflow  : sticky, a decrement hit a counter already at zero
//   perf_stalls / perf_fires : running totals of stalled / fired channel-cycles
module vx_pending_scoreboard
    import vx_pending_scoreboard_pkg::*;
#(
    parameter int NUM_CHANNELS = 1,
    parameter int NUM_WARPS    = 4,
    parameter int NUM_REGS     = 64,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int ALLOW_WAW    = 0,
    parameter int ZERO_REG     = 1,
    parameter int ASYNC_W      = DEF_ASYNC_W,
    parameter int DATAW        = DEF_DATAW,
    parameter int TIMEOUT      = 1000,
    parameter int PERF_W       = 44,
    localparam int WIS_W       = calc_wis_w(NUM_WARPS),
    localparam int RW          = calc_rw(NUM_REGS)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_CHANNELS-1:0]       in_valid,
    output logic [NUM_CHANNELS-1:0]       in_ready,
    input  logic [NUM_CHANNELS*WIS_W-1:0] in_wis,
    input  logic [NUM_CHANNELS*RW-1:0]    in_rd,
    input  logic [NUM_CHANNELS*RW-1:0]    in_rs1,
    input  logic [NUM_CHANNELS*RW-1:0]    in_rs2,
    input  logic [NUM_CHANNELS*RW-1:0]    in_rs3,
    input  logic [NUM_CHANNELS-1:0]       in_wb,
    input  logic [NUM_CHANNELS-1:0]       in_async_start,
    input  logic [NUM_CHANNELS-1:0]       in_async_wait,
    input  logic [NUM_CHANNELS*DATAW-1:0] in_data,
    output logic [NUM_CHANNELS-1:0]       out_valid,
    input  logic [NUM_CHANNELS-1:0]       out_ready,
    output logic [NUM_CHANNELS*DATAW-1:0] out_data,
    input  logic [NUM_CHANNELS-1:0]       wb_valid,
    input  logic [NUM_CHANNELS-1:0]       wb_eop,
    input  logic [NUM_CHANNELS-1:0]       wb_async_done,
    input  logic [NUM_CHANNELS*WIS_W-1:0] wb_wis,
    input  logic [NUM_CHANNELS*RW-1:0]    wb_rd,
    output logic [NUM_CHANNELS-1:0]       timeout,
    output logic [NUM_CHANNELS-1:0]       err_underflow,
    output logic [PERF_W-1:0]             perf_stalls,
    output logic [PERF_W-1:0]             perf_fires
);

    localparam logic [CNT_W-1:0]   CMAX = '1;
    localparam logic [ASYNC_W-1:0] AMAX = '1;
    localparam int                 TO_W = $clog2(TIMEOUT + 1);

    logic [NUM_CHANNELS-1:0] fire;
    logic [NUM_CHANNELS-1:0] stalled;

    // Register 0 is hardwired when ZERO_REG is set, so it never carries a dependency.
    function automatic logic tracked(input logic [RW-1:0] r);
        return !((ZERO_REG != 0) && (r == '0));
    endfunction

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
        logic [WIS_W-1:0]   wis;
        logic [WIS_W-1:0]   w_wis;
        logic [RW-1:0]      rd;
        logic [RW-1:0]      rs1;
        logic [RW-1:0]      rs2;
        logic [RW-1:0]      rs3;
        logic [RW-1:0]      w_rd;

        logic [CNT_W-1:0]   cnt  [NUM_WARPS][NUM_REGS];
        logic [ASYNC_W-1:0] acnt [NUM_WARPS];
        logic               err_q;
        logic [TO_W-1:0]    stall_cnt;

        logic [CNT_W-1:0]   rd_cnt;
        logic [ASYNC_W-1:0] a_cur;
        logic               src_busy;
        logic               rd_busy;
        logic               async_busy;
        logic               operands_ready;
        logic               stage_ready;

        logic               inc_en;
        logic               dec_en;
        logic               same_entry;
        logic               a_inc;
        logic               a_dec;
        logic               a_same;

        assign wis   = in_wis[c*WIS_W +: WIS_W];
        assign w_wis = wb_wis[c*WIS_W +: WIS_W];
        assign rd    = in_rd[c*RW +: RW];
        assign rs1   = in_rs1[c*RW +: RW];
        assign rs2   = in_rs2[c*RW +: RW];
        assign rs3   = in_rs3[c*RW +: RW];
        assign w_rd  = wb_rd[c*RW +: RW];

        // Busy checks read registered counters only: a writeback in this cycle
        // unblocks the dependent instruction one cycle later.
        always_comb begin
            rd_cnt     = cnt[wis][rd];
            a_cur      = acnt[wis];
            src_busy   = (tracked(rs1) && (cnt[wis][rs1] != '0))
                      || (tracked(rs2) && (cnt[wis][rs2] != '0))
                      || (tracked(rs3) && (cnt[wis][rs3] != '0));
            rd_busy    = in_wb[c] && tracked(rd)
                      && ((ALLOW_WAW != 0) ? (rd_cnt == CMAX) : (rd_cnt != '0));
            async_busy = (in_async_start[c] && (a_cur == AMAX))
                      || (in_async_wait[c] && (a_cur != '0));
            operands_ready = !(src_busy || rd_busy || async_busy);
        end

        assign in_ready[c] = reset_n && stage_ready && operands_ready;
        assign fire[c]     = in_valid[c] && in_ready[c];
        assign stalled[c]  = in_valid[c] && !in_ready[c];

        vx_stream_buffer #(
            .DATAW (DATAW)
        ) u_stage (
            .clk       (clk),
            .reset_n   (reset_n),
            .in_valid  (in_valid[c] && operands_ready && reset_n),
            .in_data   (in_data[c*DATAW +: DATAW]),
            .in_ready  (stage_ready),
            .out_valid (out_valid[c]),
            .out_data  (out_data[c*DATAW +: DATAW]),
            .out_ready (out_ready[c])
        );

        assign inc_en     = fire[c] && in_wb[c] && tracked(rd);
        assign dec_en     = wb_valid[c] && wb_eop[c] && tracked(w_rd);
        assign same_entry = (wis == w_wis) && (rd == w_rd);
        assign a_inc      = fire[c] && in_async_start[c];
        assign a_dec      = wb_valid[c] && wb_async_done[c];
        assign a_same     = (wis == w_wis);

        // A coincident increment and decrement on one entry cancel, which also
        // means a decrement paired with an increment at zero is not an underflow.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int w = 0; w < NUM_WARPS; w++) begin
                    for (int r = 0; r < NUM_REGS; r++) begin
                        cnt[w][r] <= '0;
                    end
                    acnt[w] <= '0;
                end
                err_q <= 1'b0;
            end else begin
                if (!(inc_en && dec_en && same_entry)) begin
                    if (dec_en) begin
                        if (cnt[w_wis][w_rd] == '0) begin
                            err_q <= 1'b1;
                        end else begin
                            cnt[w_wis][w_rd] <= cnt[w_wis][w_rd] - CNT_W'(1);
                        end
                    end
                    if (inc_en) begin
                        cnt[wis][rd] <= cnt[wis][rd] + CNT_W'(1);
                    end
                end
                if (!(a_inc && a_dec && a_same)) begin
                    if (a_dec) begin
                        if (acnt[w_wis] == '0) begin
                            err_q <= 1'b1;
                        end else begin
                            acnt[w_wis] <= acnt[w_wis] - ASYNC_W'(1);
                        end
                    end
                    if (a_inc) begin
                        acnt[wis] <= acnt[wis] + ASYNC_W'(1);
                    end
                end
            end
        end

        // Any non-stalled cycle (including a fire) breaks the consecutive run.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                stall_cnt <= '0;
            end else if (!stalled[c]) begin
                stall_cnt <= '0;
            end else if (stall_cnt != TO_W'(TIMEOUT)) begin
                stall_cnt <= stall_cnt + TO_W'(1);
            end
        end

        assign timeout[c]       = (stall_cnt == TO_W'(TIMEOUT));
        assign err_underflow[c] = err_q;
    end

    logic [PERF_W-1:0] stall_sum;
    logic [PERF_W-1:0] fire_sum;

    always_comb begin
        stall_sum = '0;
        fire_sum  = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            stall_sum = stall_sum + PERF_W'(stalled[c]);
            fire_sum  = fire_sum + PERF_W'(fire[c]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_stalls <= '0;
            perf_fires  <= '0;
        end else begin
            perf_stalls <= perf_stalls + stall_sum;
            perf_fires  <= perf_fires + fire_sum;
        end
    end

endmodule

// File: tb/tb_vx_pending_scoreboard.sv
// tb/tb_vx_pending_scoreboard.sv - self-checking bench: instance 0 with ALLOW_WAW=0, instance 1 with ALLOW_WAW=1
module tb_vx_pending_scoreboard;
    import vx_pending_scoreboard_pkg::*;

    localparam int TO   = 12;
    localparam int NW   = 4;
    localparam int NR   = 64;
    localparam int CMAX = 3;
    localparam int AMAX = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic [1:0]        in_valid, in_ready, in_wb, in_astart, in_await;
    logic [1:0]        out_valid, out_ready, wb_valid, wb_eop, wb_adone, timeout, err;
    logic [1:0][1:0]   in_wis, wb_wis;
    logic [1:0][5:0]   in_rd, in_rs1, in_rs2, in_rs3, wb_rd;
    logic [1:0][63:0]  in_data, out_data;
    logic [1:0][43:0]  perf_stalls, perf_fires;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        vx_pending_scoreboard #(.ALLOW_WAW(k), .TIMEOUT(TO)) dut (
            .clk(clk), .reset_n(reset_n),
            .in_valid(in_valid[k]), .in_ready(in_ready[k]), .in_wis(in_wis[k]),
            .in_rd(in_rd[k]), .in_rs1(in_rs1[k]), .in_rs2(in_rs2[k]), .in_rs3(in_rs3[k]),
            .in_wb(in_wb[k]), .in_async_start(in_astart[k]), .in_async_wait(in_await[k]),
            .in_data(in_data[k]), .out_valid(out_valid[k]), .out_ready(out_ready[k]),
            .out_data(out_data[k]), .wb_valid(wb_valid[k]), .wb_eop(wb_eop[k]),
            .wb_async_done(wb_adone[k]), .wb_wis(wb_wis[k]), .wb_rd(wb_rd[k]),
            .timeout(timeout[k]), .err_underflow(err[k]),
            .perf_stalls(perf_stalls[k]), .perf_fires(perf_fires[k])
        );
    end

    // Reference model: plain integer counters and a payload queue per instance.
    int       m_cnt  [2][NW][NR];
    int       m_acnt [2][NW];
    bit       m_err  [2];
    int       m_stall[2];
    longint   m_pst  [2];
    longint   m_pfi  [2];
    payload_t m_q    [2][$];

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_ready(input int k);
        int w  = int'(in_wis[k]);
        int rd = int'(in_rd[k]);
        if (m_q[k].size() >= 2) return 1'b0;
        if (in_rs1[k] != 0 && m_cnt[k][w][int'(in_rs1[k])] != 0) return 1'b0;
        if (in_rs2[k] != 0 && m_cnt[k][w][int'(in_rs2[k])] != 0) return 1'b0;
        if (in_rs3[k] != 0 && m_cnt[k][w][int'(in_rs3[k])] != 0) return 1'b0;
        if (in_wb[k] && rd != 0) begin
            if (k == 0 && m_cnt[k][w][rd] != 0) return 1'b0;
            if (k == 1 && m_cnt[k][w][rd] == CMAX) return 1'b0;
        end
        if (in_astart[k] && m_acnt[k][w] == AMAX) return 1'b0;
        if (in_await[k] && m_acnt[k][w] != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            for (int w = 0; w < NW; w++) begin
                for (int r = 0; r < NR; r++) m_cnt[k][w][r] = 0;
                m_acnt[k][w] = 0;
            end
            m_err[k] = 1'b0; m_stall[k] = 0; m_pst[k] = 0; m_pfi[k] = 0;
            m_q[k].delete();
        end
    endtask

    // Called at a falling edge with inputs already applied: compare, advance model, advance one cycle.
    task automatic step();
        bit rdy[2];
        bit f, s, inc, dec;
        int w, rd, ww, wr;
        #1;
        for (int k = 0; k < 2; k++) begin
            rdy[k] = exp_ready(k);
            check($sformatf("in_ready[%0d]", k), 64'(in_ready[k]), 64'(rdy[k]));
            check($sformatf("out_valid[%0d]", k), 64'(out_valid[k]), 64'(m_q[k].size() != 0));
            if (m_q[k].size() != 0)
                check($sformatf("out_data[%0d]", k), out_data[k], m_q[k][0].data);
            check($sformatf("timeout[%0d]", k), 64'(timeout[k]), 64'(m_stall[k] == TO));
            check($sformatf("err_underflow[%0d]", k), 64'(err[k]), 64'(m_err[k]));
            check($sformatf("perf_stalls[%0d]", k), 64'(perf_stalls[k]), 64'(m_pst[k]));
            check($sformatf("perf_fires[%0d]", k), 64'(perf_fires[k]), 64'(m_pfi[k]));
        end
        for (int k = 0; k < 2; k++) begin
            f  = in_valid[k] && rdy[k];
            s  = in_valid[k] && !rdy[k];
            w  = int'(in_wis[k]);  rd = int'(in_rd[k]);
            ww = int'(wb_wis[k]);  wr = int'(wb_rd[k]);
            if (m_q[k].size() != 0 && out_ready[k]) void'(m_q[k].pop_front());
            if (f) m_q[k].push_back(payload_t'(in_data[k]));
            inc = f && in_wb[k] && rd != 0;
            dec = wb_valid[k] && wb_eop[k] && wr != 0;
            if (!(inc && dec && w == ww && rd == wr)) begin
                if (dec) begin
                    if (m_cnt[k][ww][wr] == 0) m_err[k] = 1'b1;
                    else m_cnt[k][ww][wr]--;
                end
                if (inc) m_cnt[k][w][rd]++;
            end
            inc = f && in_astart[k];
            dec = wb_valid[k] && wb_adone[k];
            if (!(inc && dec && w == ww)) begin
                if (dec) begin
                    if (m_acnt[k][ww] == 0) m_err[k] = 1'b1;
                    else m_acnt[k][ww]--;
                end
                if (inc) m_acnt[k][w]++;
            end
            m_stall[k] = s ? ((m_stall[k] < TO) ? m_stall[k] + 1 : TO) : 0;
            m_pst[k] += longint'(s);
            m_pfi[k] += longint'(f);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input int k, input bit v, input int w, input int rd, input int rs1,
                         input bit wb, input bit as = 1'b0, input bit aw = 1'b0);
        in_valid[k] = v;   in_wis[k] = 2'(w);  in_rd[k] = 6'(rd);
        in_rs1[k] = 6'(rs1); in_rs2[k] = 6'd0; in_rs3[k] = 6'd0;
        in_wb[k] = wb;     in_astart[k] = as;  in_await[k] = aw;
        in_data[k] = {$urandom, $urandom};
    endtask

    task automatic wback(input int k, input bit v, input int w, input int rd, input bit eop, input bit ad);
        wb_valid[k] = v; wb_wis[k] = 2'(w); wb_rd[k] = 6'(rd); wb_eop[k] = eop; wb_adone[k] = ad;
    endtask

    task automatic idle_all();
        for (int k = 0; k < 2; k++) begin
            issue(k, 1'b0, 0, 0, 0, 1'b0);
            wback(k, 1'b0, 0, 0, 1'b0, 1'b0);
        end
        out_ready = 2'b11;
    endtask

    // Reset is asserted away from any clock edge to exercise the asynchronous path.
    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_in_ready[%0d]", k), 64'(in_ready[k]), 64'd0);
            check($sformatf("rst_out_valid[%0d]", k), 64'(out_valid[k]), 64'd0);
            check($sformatf("rst_out_data[%0d]", k), out_data[k], 64'd0);
            check($sformatf("rst_timeout[%0d]", k), 64'(timeout[k]), 64'd0);
            check($sformatf("rst_err[%0d]", k), 64'(err[k]), 64'd0);
            check($sformatf("rst_perf_stalls[%0d]", k), 64'(perf_stalls[k]), 64'd0);
            check($sformatf("rst_perf_fires[%0d]", k), 64'(perf_fires[k]), 64'd0);
        end
        model_clear();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b1;
        idle_all();
        do_reset();
        idle_all();
        step();

        // RAW on instance 0: rs1=5 waits for the writeback, released one cycle after it.
        issue(0, 1'b1, 0, 5, 0, 1'b1);          step();
        issue(0, 1'b1, 0, 1, 5, 1'b0);          repeat (3) step();
        wback(0, 1'b1, 0, 5, 1'b1, 1'b0);       step();
        wback(0, 1'b0, 0, 0, 1'b0, 1'b0);
        check("raw_release", 64'(in_ready[0]), 64'd1);
        step();
        idle_all();                              step();

        // WAW allowed on instance 1: three back-to-back, fourth waits for one writeback.
        issue(1, 1'b1, 1, 7, 0, 1'b1);          repeat (4) step();
        check("waw_fourth_stalled", 64'(in_ready[1]), 64'd0);
        wback(1, 1'b1, 1, 7, 1'b1, 1'b0);       step();
        wback(1, 1'b0, 0, 0, 1'b0, 1'b0);       step();
        idle_all();                              step();

        // Coincident increment and decrement on w2 rd3 at count 1.
        issue(1, 1'b1, 2, 3, 0, 1'b1);          step();
        wback(1, 1'b1, 2, 3, 1'b1, 1'b0);       step();
        idle_all();
        wback(1, 1'b1, 2, 3, 1'b1, 1'b0);       step();
        idle_all();                              step();
        check("coincident_no_err", 64'(err[1]), 64'd0);

        // Async: 15 starts fire, the 16th stalls; wait releases after 15 completions.
        issue(0, 1'b1, 0, 0, 0, 1'b0, 1'b1, 1'b0); repeat (16) step();
        check("async_full_stall", 64'(in_ready[0]), 64'd0);
        issue(0, 1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        wback(0, 1'b1, 0, 0, 1'b0, 1'b1);       repeat (15) step();
        wback(0, 1'b0, 0, 0, 1'b0, 1'b0);
        check("async_wait_release", 64'(in_ready[0]), 64'd1);
        step();
        idle_all();                              step();

        // Writeback to register 0 is ignored; writeback to idle w3 rd9 underflows and sticks.
        wback(1, 1'b1, 3, 0, 1'b1, 1'b0);       step();
        wback(1, 1'b0, 0, 0, 1'b0, 1'b0);       step();
        wback(0, 1'b1, 3, 9, 1'b1, 1'b0);       step();
        wback(0, 1'b0, 0, 0, 1'b0, 1'b0);       repeat (3) step();
        check("err_sticky", 64'(err[0]), 64'd1);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 2; k++) begin
                issue(k, $urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 7),
                      $urandom_range(0, 7), $urandom_range(0, 1) != 0,
                      $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
                in_rs2[k] = 6'($urandom_range(0, 7));
                in_rs3[k] = 6'($urandom_range(0, 7));
                wback(k, $urandom_range(0, 1) != 0, $urandom_range(0, 3), $urandom_range(0, 7),
                      $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
                out_ready[k] = $urandom_range(0, 3) != 0;
            end
            step();
        end

        // Back-pressure: two entries accepted, then stall into timeout, then a mid-operation reset.
        idle_all();
        do_reset();
        idle_all();
        out_ready = 2'b00;
        issue(0, 1'b1, 0, 0, 0, 1'b0);          repeat (TO + 4) step();
        check("bp_in_ready_low", 64'(in_ready[0]), 64'd0);
        check("bp_timeout", 64'(timeout[0]), 64'd1);
        check("bp_out_valid", 64'(out_valid[0]), 64'd1);
        do_reset();
        idle_all();
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/vx_pending_scoreboard.md
VX_PENDING_SCOREBOARD -- requirements
Module: VX_pending_scoreboard

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, 1: independent issue channels.
REQ-002 SHALL have parameter NUM_WARPS, 4: warps per channel (WIS_W = max(1, clog2 NUM_WARPS)).
REQ-003 SHALL have parameter NUM_REGS, 64: architectural registers per warp (RW = clog2 NUM_REGS).
REQ-004 SHALL have parameter CNT_W, 2: width of each per-register pending-write counter.
REQ-005 SHALL have parameter ALLOW_WAW, 0: 1 = issue to a pending rd allowed while its counter is below max.
REQ-006 SHALL have parameter ZERO_REG, 1: 1 = register 0 is never tracked.
REQ-007 SHALL have parameter ASYNC_W, 4: width of the per-warp async-unit in-flight counter.
REQ-008 SHALL have parameter DATAW, 64: opaque payload width; TIMEOUT, 1000: stall-cycle limit; PERF_W, 44: perf counter width.
REQ-009 SHALL provide: clk  in  1  clock, all state on rising edge.
REQ-010 SHALL provide: reset_n  in  1  one clock; reset is asynchronous and active-low.
REQ-011 SHALL provide: in_valid / in_ready  in / out  NUM_CHANNELS  issue handshake per channel.
REQ-012 SHALL provide: in_wis  in  NUM_CHANNELS*WIS_W; in_rd, in_rs1, in_rs2, in_rs3  in  NUM_CHANNELS*RW each.
REQ-013 SHALL provide: in_wb, in_async_start, in_async_wait  in  NUM_CHANNELS each; in_data  in  NUM_CHANNELS*DATAW.
REQ-014 SHALL provide: out_valid / out_ready  out / in  NUM_CHANNELS; out_data  out  NUM_CHANNELS*DATAW.
REQ-015 SHALL provide: wb_valid, wb_eop, wb_async_done  in  NUM_CHANNELS each; wb_wis  in  NUM_CHANNELS*WIS_W; wb_rd  in  NUM_CHANNELS*RW.
REQ-016 SHALL provide: timeout  out  NUM_CHANNELS; err_underflow  out  NUM_CHANNELS; perf_stalls, perf_fires  out  PERF_W each.

Function
REQ-017 Per channel, each (warp, reg) pair SHALL hold an unsigned CNT_W-bit pending counter; CMAX = 2^CNT_W-1.
REQ-018 Issue fire = in_valid && in_ready; fire with in_wb SHALL increment cnt[wis][rd]; wb fire = wb_valid && wb_eop SHALL decrement cnt[wb_wis][wb_rd]; coincident increment and decrement on one entry SHALL leave it unchanged.
REQ-019 Source busy: any rs1/rs2/rs3 with cnt != 0 SHALL block issue (RAW).
REQ-020 rd busy, only when in_wb: ALLOW_WAW=0 -> cnt[rd] != 0; ALLOW_WAW=1 -> cnt[rd] == CMAX; busy rd SHALL block issue.
REQ-021 ZERO_REG=1: register 0 SHALL never be busy, never increment, never decrement, and a writeback to it SHALL be ignored.
REQ-022 Writeback fire to a counter at 0 SHALL leave it at 0 and set sticky err_underflow for that channel.
REQ-023 Busy evaluation SHALL use registered counters only; a same-cycle writeback SHALL NOT unblock issue until the next cycle.
REQ-024 Per warp, an ASYNC_W-bit counter SHALL increment on fire with in_async_start and decrement on wb_valid && wb_async_done, indexed by wb_wis; coincident events on one warp SHALL leave it unchanged; decrement at 0 SHALL hold 0 and set err_underflow.
REQ-025 in_async_start SHALL block while the warp counter equals its max; in_async_wait SHALL block while the warp counter != 0.
REQ-026 in_ready SHALL equal stage_ready && operands_ready; in_valid SHALL NOT depend combinationally on in_ready.
REQ-027 Each channel SHALL have a two-entry output stage: out_valid 1 cycle after issue fire; full throughput; out_data equals in_data in order; in_ready independent of out_ready in the same cycle.
REQ-028 Per channel, a stall counter SHALL count consecutive cycles of in_valid && !in_ready, saturate at TIMEOUT, clear on fire; timeout SHALL be high while the counter equals TIMEOUT.
REQ-029 perf_stalls / perf_fires SHALL add the per-cycle count of stalled / fired channels, wrapping modulo 2^PERF_W.

Reset
REQ-030 On reset_n low, asynchronously: all counters 0, output stages empty, out_valid 0, timeout 0, err_underflow 0, perf counters 0.
REQ-031 Reset asserted mid-operation SHALL discard staged entries and all pending state; in_ready SHALL be 0 while reset_n is low.

Structure
REQ-032 CNT_W, ASYNC_W, the WIS_W/RW derivations and the payload struct SHALL live in the shared GPU package.
REQ-033 The output stage SHALL be one sub-module, VX_stream_buffer, instantiated per channel; counter logic SHALL be inline.

Verification
REQ-034 ALLOW_WAW=0: issue w0 rd=5 wb=1, then w0 rs1=5 -> stalled until a wb on w0 rd=5; in_ready rises the cycle after that wb.
REQ-035 ALLOW_WAW=1, CNT_W=2: three issues to w1 rd=7 fire back-to-back; the fourth stalls; one writeback -> fourth fires next cycle.
REQ-036 Same-cycle issue wb=1 and writeback on w2 rd=3 at cnt=1 -> cnt stays 1, err_underflow stays 0.
REQ-037 Sixteen async_start on w0 with ASYNC_W=4 -> 15 fire, 16th stalls; async_wait stalls until 15 async_done pulses, then fires.
REQ-038 Writeback to idle w3 rd=9 -> err_underflow=1 sticky, cnt stays 0; writeback to rd=0 with ZERO_REG=1 -> ignored, no error.
REQ-039 out_ready held 0 with continuous valid issue -> two entries accepted, then in_ready=0; timeout asserts after TIMEOUT stalled cycles; reset_n pulse -> all outputs 0.
